rf_write_ctrl: RTL

//  Write-side front end for the register file: turns a raw active-low push-button into exactly one

---
 rtl/rf_write_ctrl.sv | 121 ++++++++++++
 1 files changed

// File: rtl/rf_write_ctrl.sv
// Debounced push-button to single-cycle register-file write strobe, with committed-write counter.
// Optional feature macro RF_WRITE_AUTOINC_EN: write address comes from an internal auto-incrementing pointer.
module rf_write_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int ADDR_W          = 4,
  parameter int DATA_W          = 8
) (
  input  logic              CLOCK_50,
  input  logic              RESET,
  input  logic              KEY_N,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              RFWrite,
  output logic [ADDR_W-1:0] regW,
  output logic [DATA_W-1:0] dataW,
  output logic              busy,
  output logic [7:0]        write_count
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, DEB_PRESS, WRITE, WAIT_REL, DEB_REL} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            ks_meta;
  logic            ks;
  logic [ADDR_W-1:0] cap_addr;

`ifdef RF_WRITE_AUTOINC_EN
  logic [ADDR_W-1:0] ptr;
  assign cap_addr = ptr;
`else
  assign cap_addr = addr_in;
`endif

  // Synchroniser resets to "released" so a key held through reset is seen as a fresh press.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      ks_meta <= 1'b1;
      ks      <= 1'b1;
    end else begin
      ks_meta <= KEY_N;
      ks      <= ks_meta;
    end
  end

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      state       <= IDLE;
      cnt         <= '0;
      RFWrite     <= 1'b0;
      regW        <= '0;
      dataW       <= '0;
      busy        <= 1'b0;
      write_count <= 8'd0;
`ifdef RF_WRITE_AUTOINC_EN
      ptr         <= '0;
`endif
    end else begin
      RFWrite <= 1'b0;
      case (state)
        IDLE: begin
          if (!ks) begin
            state <= DEB_PRESS;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        DEB_PRESS: begin
          if (ks) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            state   <= WRITE;
            cnt     <= '0;
            RFWrite <= 1'b1;
            regW    <= cap_addr;
            dataW   <= data_in;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        WRITE: begin
          state       <= WAIT_REL;
          cnt         <= '0;
          write_count <= write_count + 8'd1;
`ifdef RF_WRITE_AUTOINC_EN
          ptr         <= ptr + ADDR_W'(1);
`endif
        end
        WAIT_REL: begin
          if (ks) begin
            state <= DEB_REL;
            cnt   <= '0;
          end
        end
        DEB_REL: begin
          if (!ks) begin
            state <= WAIT_REL;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
